// File: rtl/wb_pl_ram_slave.sv
// Wishbone B4 pipelined slave in front of a single-port 32-bit word RAM.
// Acks come back in order, a fixed 1+WAIT_STATES cycles after accept; an outstanding-request counter drives stall.
module wb_pl_ram_slave #(
   parameter int ADDR_WIDTH      = 10,
   parameter int WAIT_STATES     = 0,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_stall_o
);

   localparam int DEPTH = 1 + WAIT_STATES;
   localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
   localparam int WORDS = 1 << ADDR_WIDTH;

   logic [31:0]             mem_q [WORDS];
   logic [DEPTH-1:0]        vld_q, vld_d;
   logic [DEPTH-1:0]        we_q, we_d;
   logic [DEPTH-1:0][31:0]  dat_q;
   logic [CW-1:0]           outst_q, outst_d;
   logic [31:0]             hold_q, hold_d;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    accept;
   logic                    ack;
   logic                    rd_ack;
   logic                    unused_adr;

   // Byte-offset and upper address bits are deliberately ignored, so addresses alias.
   assign idx        = wb_adr_i[ADDR_WIDTH+1:2];
   assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

   assign wb_stall_o = (outst_q == CW'(MAX_OUTSTANDING));
   assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~rst;
   assign ack        = wb_cyc_i & vld_q[DEPTH-1];
   assign rd_ack     = ack & ~we_q[DEPTH-1];
   assign wb_ack_o   = ack;
   assign wb_dat_o   = rd_ack ? dat_q[DEPTH-1] : hold_q;

   // RAM port and the data half of the pipeline; neither needs a reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (wb_we_i) begin
            for (int n = 0; n < 4; n++)
               if (wb_sel_i[n]) mem_q[idx][8*n +: 8] <= wb_dat_i[8*n +: 8];
         end else begin
            dat_q[0] <= mem_q[idx];
         end
      end
      for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
   end

   always_comb begin
      vld_d   = '0;
      we_d    = '0;
      outst_d = outst_q;
      hold_d  = hold_q;
      vld_d[0] = accept;
      we_d[0]  = wb_we_i;
      for (int i = 1; i < DEPTH; i++) begin
         vld_d[i] = vld_q[i-1];
         we_d[i]  = we_q[i-1];
      end
      if (rd_ack) hold_d = dat_q[DEPTH-1];
      // Dropping cyc abandons everything in flight.
      if (!wb_cyc_i) begin
         vld_d   = '0;
         outst_d = '0;
      end else if (accept && !ack) begin
         outst_d = outst_q + CW'(1);
      end else if (!accept && ack) begin
         outst_d = outst_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         we_q    <= '0;
         outst_q <= '0;
         hold_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         we_q    <= we_d;
         outst_q <= outst_d;
         hold_q  <= hold_d;
      end
   end

endmodule

// File: tb/tb_wb_pl_ram_slave.sv
// Bench for wb_pl_ram_slave: two instances (0 and 2 wait states) share one bus stimulus.
// Each instance is compared every cycle against a slot-per-cycle model of the expected acks.
module tb_wb_pl_ram_slave;
   localparam int AW   = 10;
   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat;
   logic [31:0] dat0, dat1;
   logic        ack0, ack1, stall0, stall1;

   always #5 clk = ~clk;

   wb_pl_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .MAX_OUTSTANDING(MAXO)) u0 (
      .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_stall_o(stall0));

   wb_pl_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2), .MAX_OUTSTANDING(MAXO)) u1 (
      .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_stall_o(stall1));

   // Model: slot k holds the ack due in cycle k (mod 16), filled at accept time.
   int          n_chk = 0, n_err = 0;
   int unsigned cyc_n = 0;
   int          lat [2] = '{1, 3};
   bit          sv [2][16];
   bit          sw [2][16];
   bit          sk [2][16];
   logic [31:0] sd [2][16];
   logic [31:0] mm [2][1<<AW];
   bit          mk [2][1<<AW];
   logic [31:0] hold [2];
   bit          hk [2];
   bit          acc_r [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, obs, exp);
      end
   endtask

   function automatic int busy(input int i);
      int n = 0;
      for (int k = 0; k < 16; k++) n += int'(sv[i][k]);
      return n;
   endfunction

   task automatic check_outputs();
      int   c;
      bit   ea;
      logic a, s;
      logic [31:0] d;
      c = int'(cyc_n % 16);
      for (int i = 0; i < 2; i++) begin
         a  = (i == 0) ? ack0 : ack1;
         s  = (i == 0) ? stall0 : stall1;
         d  = (i == 0) ? dat0 : dat1;
         ea = cyc && sv[i][c];
         chk($sformatf("ack[%0d]", i), 32'(a), 32'(ea));
         chk($sformatf("stall[%0d]", i), 32'(s), 32'(busy(i) == MAXO));
         if (ea && !sw[i][c]) begin
            if (sk[i][c]) chk($sformatf("rdata[%0d]", i), d, sd[i][c]);
         end else if (hk[i]) begin
            chk($sformatf("hold[%0d]", i), d, hold[i]);
         end
      end
   endtask

   task automatic step();
      int c, slot;
      int unsigned ix;
      bit ea;
      c  = int'(cyc_n % 16);
      ix = 32'(adr[AW+1:2]);
      for (int i = 0; i < 2; i++) begin
         ea       = cyc && sv[i][c];
         acc_r[i] = !rst && cyc && stb && (busy(i) != MAXO);
         if (rst) begin
            for (int k = 0; k < 16; k++) sv[i][k] = 1'b0;
            hold[i] = '0;
            hk[i]   = 1'b1;
         end else begin
            if (ea) begin
               if (!sw[i][c]) begin
                  hold[i] = sd[i][c];
                  hk[i]   = sk[i][c];
               end
               sv[i][c] = 1'b0;
            end
            if (!cyc)
               for (int k = 0; k < 16; k++) sv[i][k] = 1'b0;
            if (acc_r[i]) begin
               slot = int'((cyc_n + 32'(lat[i])) % 16);
               sv[i][slot] = 1'b1;
               sw[i][slot] = we;
               if (we) begin
                  for (int n = 0; n < 4; n++)
                     if (sel[n]) mm[i][ix][8*n +: 8] = dat[8*n +: 8];
                  if (sel == 4'hF) mk[i][ix] = 1'b1;
               end else begin
                  sd[i][slot] = mm[i][ix];
                  sk[i][slot] = mk[i][ix];
               end
            end
         end
      end
      cyc_n++;
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit c, input bit s, input bit w, input logic [3:0] sl,
                        input logic [31:0] a, input logic [31:0] d);
      cyc = c; stb = s; we = w; sel = sl; adr = a; dat = d;
   endtask

   task automatic idle(input int n);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Holds the request until the target instance has accepted it (bounded).
   task automatic req(input int tgt, input bit w, input logic [3:0] sl,
                      input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b1, w, sl, a, d);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (acc_r[tgt]) break;
      end
      chk($sformatf("accepted[%0d]", tgt), 32'(acc_r[tgt]), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         hold[i] = '0;
         hk[i]   = 1'b1;
      end
      tick();
      rst = 1'b0;
      idle(2);

      // Full write then immediate read-back
      req(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      req(1, 1'b0, 4'h0, 32'h10, 32'h0);
      idle(5);

      // Byte-lane merge and empty-select write
      req(1, 1'b1, 4'hF, 32'h80, 32'h11223344);
      req(1, 1'b1, 4'h2, 32'h80, 32'h0000AA00);
      req(1, 1'b0, 4'h1, 32'h80, 32'h0);
      req(1, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF);
      req(1, 1'b0, 4'h0, 32'h80, 32'h0);
      idle(5);

      // Preload then four back-to-back reads
      for (int k = 0; k < 4; k++) begin
         req(1, 1'b1, 4'hF, 32'(4 * k), 32'(k + 1));
         idle(3);
      end
      for (int k = 0; k < 4; k++) req(1, 1'b0, 4'hF, 32'(4 * k), 32'h0);
      idle(6);

      // Abort with two reads in flight, then a fresh read
      req(1, 1'b0, 4'hF, 32'h0, 32'h0);
      req(1, 1'b0, 4'hF, 32'h4, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      req(1, 1'b0, 4'hF, 32'h8, 32'h0);
      idle(6);

      // Address aliasing
      req(1, 1'b1, 4'hF, 32'h1000, 32'hCAFE0001);
      req(1, 1'b0, 4'hF, 32'h0, 32'h0);
      req(1, 1'b0, 4'hF, 32'h3, 32'h0);
      idle(6);

      // Reset with requests in flight; RAM must survive
      req(1, 1'b0, 4'hF, 32'h80, 32'h0);
      req(1, 1'b0, 4'hF, 32'h10, 32'h0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(4);
      req(1, 1'b0, 4'hF, 32'h10, 32'h0);
      req(1, 1'b0, 4'hF, 32'h80, 32'h0);
      idle(6);

      // Randomized traffic over a small aliased window
      for (int k = 0; k < 800; k++) begin
         logic [31:0] a;
         a = $urandom;
         a[AW+1:2] = AW'($urandom_range(0, 15));
         rst = ($urandom_range(0, 99) == 0);
         drive(($urandom_range(0, 9) != 0), (!rst && $urandom_range(0, 2) != 0),
               1'($urandom), 4'($urandom), a, $urandom);
         tick();
      end
      rst = 1'b0;
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
